// File: rtl/ram32x1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram32x1_pkg
// Description : Shared sizes, state encoding and X-merge helper for the
//               32x1 writable memory cell and its read mux.
// Revision    : 1.0 - initial release
// ============================================================================
package ram32x1_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Merge two candidate read values: keep the value when identical, else X.
    function automatic logic data_same(input logic a, input logic b);
        return (a === b) ? a : 1'bx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram32x1_rdmux.sv
`default_nettype none
// ============================================================================
// Module      : ram32x1_rdmux
// Description : X-propagating 2^SEL_W:1 read mux, built as a recursive tree
//               of 2:1 stages split on the select MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module ram32x1_rdmux
    import ram32x1_pkg::*;
#(
    parameter int SEL_W = AW
)
(
    input  logic [(1<<SEL_W)-1:0] i_data,
    input  logic [SEL_W-1:0]      i_sel,
    output logic                  o_dout
);

    logic w_lo;
    logic w_hi;

    generate
        if (SEL_W == 1) begin : g_leaf
            assign w_lo = i_data[0];
            assign w_hi = i_data[1];
        end else begin : g_node
            localparam int HALF = 1 << (SEL_W - 1);

            ram32x1_rdmux #(.SEL_W(SEL_W - 1)) u_lo (
                .i_data (i_data[HALF-1:0]),
                .i_sel  (i_sel[SEL_W-2:0]),
                .o_dout (w_lo)
            );

            ram32x1_rdmux #(.SEL_W(SEL_W - 1)) u_hi (
                .i_data (i_data[2*HALF-1:HALF]),
                .i_sel  (i_sel[SEL_W-2:0]),
                .o_dout (w_hi)
            );
        end
    endgenerate

    // An unknown select bit yields the common value of both halves, or X.
    always_comb begin
        if (i_sel[SEL_W-1] === 1'b0) begin
            o_dout = w_lo;
        end else if (i_sel[SEL_W-1] === 1'b1) begin
            o_dout = w_hi;
        end else begin
            o_dout = data_same(w_lo, w_hi);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram32x1_writer.sv
`default_nettype none
// ============================================================================
// Module      : ram32x1_writer
// Description : 32x1 distributed memory cell with single-bit writes, serial
//               bulk load, sequential clear and an X-propagating async read.
// Revision    : 1.0 - initial release
// ============================================================================
module ram32x1_writer
    import ram32x1_pkg::*;
#(
    parameter logic [DEPTH-1:0] INITVAL = 32'h0000_0000
)
(
    input  logic             CK,
    input  logic             RSTN,
    input  logic             WE,
    input  logic [AW-1:0]    WAD,
    input  logic             DI,
    input  logic             LOAD_VLD,
    output logic             LOAD_RDY,
    input  logic [DEPTH-1:0] LOAD_DATA,
    input  logic             CLR,
    output logic             BUSY,
    output logic             DONE,
    input  logic [AW-1:0]    AD,
    output logic             DO0
);

    state_t           r_state;
    logic [AW-1:0]    r_cnt;
    logic [DEPTH-1:0] r_shift;
    logic [DEPTH-1:0] r_mem;
    logic             r_busy;
    logic             r_done;
    logic             r_load_rdy;
    logic             w_last;

    assign w_last = (r_cnt == AW'(DEPTH - 1));

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_mem      <= INITVAL;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_rdy <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_load_rdy <= 1'b1;
                    if (CLR) begin
                        r_state    <= CLEAR;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_load_rdy <= 1'b0;
                    end else if (LOAD_VLD && r_load_rdy) begin
                        r_shift    <= LOAD_DATA;
                        r_state    <= LOAD;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_load_rdy <= 1'b0;
                    end else begin
                        // Ternary form lets an unknown WE/WAD merge DI with
                        // the old cell value instead of silently skipping.
                        for (int i = 0; i < DEPTH; i++) begin
                            r_mem[i] <= (WE & (WAD == AW'(i))) ? DI : r_mem[i];
                        end
                    end
                end
                LOAD, CLEAR: begin
                    r_mem[r_cnt] <= (r_state == LOAD) ? r_shift[0] : 1'b0;
                    r_shift      <= r_shift >> 1;
                    r_cnt        <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_load_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign LOAD_RDY = r_load_rdy;
    assign BUSY     = r_busy;
    assign DONE     = r_done;

    ram32x1_rdmux #(.SEL_W(AW)) u_rdmux (
        .i_data (r_mem),
        .i_sel  (AD),
        .o_dout (DO0)
    );

endmodule
`default_nettype wire
